// File: rtl/dvp_pkg.sv
// Shared types and constants for the DVP test-pattern transmitter.
// Holds the frame FSM state encoding, the pattern selector and the bar palette.
// Pure declarations: no logic, no timing.
package dvp_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VBACK  = 3'd2,
    ACTIVE = 3'd3,
    VFRONT = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_SOLID = 2'd1,
    PAT_COORD = 2'd2,
    PAT_RAMP  = 2'd3
  } pattern_e;

  // RGB565 colour bars, left to right: white, yellow, cyan, green,
  // magenta, red, blue, black.
  localparam logic [15:0] BAR_RGB [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

endpackage

// File: rtl/dvp_pattern_tx_if.sv
// Camera-side DVP bus: pixel byte clock, frame/line syncs and 8-bit data.
// master = the transmitter driving the pins, slave = a capture block.
// Pure wiring: no latency, no flow control (the bus is free-running).
interface dvp_pattern_tx_if;

  logic       pclk;
  logic       vsync;
  logic       href;
  logic [7:0] data;

  modport master (output pclk, vsync, href, data);
  modport slave  (input  pclk, vsync, href, data);

endinterface

// File: rtl/dvp_pixel_gen.sv
// Test-pattern pixel generator: maps (pattern, x, y, bar, solid, frame) to RGB565.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller samples pix whenever it needs a pixel.
module dvp_pixel_gen
  import dvp_pkg::*;
(
  input  pattern_e    pattern,      // latched pattern for the current frame
  input  logic [15:0] x,            // pixel column within the line
  input  logic [7:0]  y,            // low byte of the active line index
  input  logic [2:0]  bar_idx,      // colour-bar index, maintained by the caller
  input  logic [15:0] solid_rgb,    // latched solid colour
  input  logic [15:0] frame_count,  // frames started so far, seeds the ramp
  output logic [15:0] pix
);

  always_comb begin
    pix = 16'h0000;
    case (pattern)
      PAT_BARS:  pix = BAR_RGB[bar_idx];
      PAT_SOLID: pix = solid_rgb;
      PAT_COORD: pix = {y, x[7:0]};
      PAT_RAMP:  pix = x + frame_count;
      default:   pix = 16'h0000;
    endcase
  end

endmodule

// File: rtl/dvp_pattern_tx.sv
// DVP camera emulator: OV7670-style frames of RGB565 test patterns, high byte first.
// Latency: frame starts on the first byte tick with enable high; outputs registered.
// Backpressure: none; free-running pclk, a started frame always runs to completion.
// Ports: clk/reset (sync, active high), enable, pattern_sel, solid_rgb in;
// cam (DVP bus, master), frame_start pulse, frame_count, busy out.
module dvp_pattern_tx
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10,
  parameter int PCLK_DIV    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [1:0]              pattern_sel,
  input  logic [15:0]             solid_rgb,
  dvp_pattern_tx_if.master        cam,
  output logic                    frame_start,
  output logic [15:0]             frame_count,
  output logic                    busy
);

  localparam int               DIV_W      = $clog2(PCLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(PCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF   = DIV_W'(PCLK_DIV / 2);
  localparam logic [15:0]      LINE_BYTES = 16'(2 * H_ACTIVE + H_BLANK);
  localparam logic [15:0]      HREF_BYTES = 16'(2 * H_ACTIVE);
  localparam logic [15:0]      BAR_PIX    = 16'(H_ACTIVE / 8);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             pclk_q, pclk_d;
  logic [15:0]      byte_cnt_q, byte_cnt_d;   // byte position within the line
  logic [15:0]      line_cnt_q, line_cnt_d;   // line within the current state; y in ACTIVE
  logic [15:0]      x_q, x_d;
  logic             phase_q, phase_d;         // 0 = high byte, 1 = low byte
  logic [15:0]      bar_px_q, bar_px_d;       // pixels into the current bar
  logic [2:0]       bar_idx_q, bar_idx_d;
  pattern_e         pat_q, pat_d;
  logic [15:0]      solid_q, solid_d;
  logic [7:0]       pix_lo_q, pix_lo_d;
  logic             vsync_q, vsync_d;
  logic             href_q, href_d;
  logic [7:0]       data_q, data_d;
  logic             frame_start_q, frame_start_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic             busy_q, busy_d;

  logic             byte_tick;
  logic             line_end;
  logic             last_line;
  logic             start_frame;
  logic [15:0]      state_lines;
  logic [15:0]      pix;

  // The byte tick coincides with the pclk falling edge, so everything that
  // changes on it is stable across the following rising edge.
  assign byte_tick = (div_cnt_q == DIV_LAST);

  always_comb begin
    case (state_q)
      VSYNC:   state_lines = 16'(VSYNC_LINES);
      VBACK:   state_lines = 16'(V_BACK);
      ACTIVE:  state_lines = 16'(V_ACTIVE);
      VFRONT:  state_lines = 16'(V_FRONT);
      default: state_lines = 16'd1;
    endcase
  end

  // Frame FSM and position counters. Counters describe the byte that will be
  // on the bus after this tick.
  always_comb begin
    div_cnt_d     = byte_tick ? '0 : div_cnt_q + DIV_W'(1);
    pclk_d        = (div_cnt_d >= DIV_HALF);
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    line_cnt_d    = line_cnt_q;
    x_d           = x_q;
    phase_d       = phase_q;
    bar_px_d      = bar_px_q;
    bar_idx_d     = bar_idx_q;
    pat_d         = pat_q;
    solid_d       = solid_q;
    frame_start_d = 1'b0;
    frame_count_d = frame_count_q;
    line_end      = (byte_cnt_q == LINE_BYTES - 16'd1);
    last_line     = (line_cnt_q == state_lines - 16'd1);
    start_frame   = 1'b0;

    if (byte_tick) begin
      if (line_end) begin
        byte_cnt_d = '0;
        x_d        = '0;
        phase_d    = 1'b0;
        bar_px_d   = '0;
        bar_idx_d  = '0;
      end else begin
        byte_cnt_d = byte_cnt_q + 16'd1;
        phase_d    = ~phase_q;
        // A new pixel begins after each low byte; bars advance by counting
        // pixels rather than dividing x.
        if (phase_q) begin
          x_d = x_q + 16'd1;
          if (bar_px_q == BAR_PIX - 16'd1) begin
            bar_px_d  = '0;
            bar_idx_d = bar_idx_q + 3'd1;
          end else begin
            bar_px_d  = bar_px_q + 16'd1;
          end
        end
      end

      if (line_end && state_q != IDLE) begin
        line_cnt_d = last_line ? 16'd0 : line_cnt_q + 16'd1;
      end

      case (state_q)
        IDLE:    if (enable) start_frame = 1'b1;
        VSYNC:   if (line_end && last_line) state_d = VBACK;
        VBACK:   if (line_end && last_line) state_d = ACTIVE;
        ACTIVE:  if (line_end && last_line) state_d = VFRONT;
        VFRONT: begin
          if (line_end && last_line) begin
            if (enable) start_frame = 1'b1;
            else        state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      // Pattern inputs are only sampled here, so changes wait for a frame start.
      if (start_frame) begin
        state_d       = VSYNC;
        byte_cnt_d    = '0;
        line_cnt_d    = '0;
        x_d           = '0;
        phase_d       = 1'b0;
        bar_px_d      = '0;
        bar_idx_d     = '0;
        pat_d         = pattern_e'(pattern_sel);
        solid_d       = solid_rgb;
        frame_start_d = 1'b1;
        frame_count_d = frame_count_q + 16'd1;
      end

      if (state_d == IDLE) begin
        byte_cnt_d = '0;
        line_cnt_d = '0;
        x_d        = '0;
        phase_d    = 1'b0;
        bar_px_d   = '0;
        bar_idx_d  = '0;
      end
    end

    busy_d = (state_d != IDLE);
  end

  dvp_pixel_gen u_pixel_gen (
    .pattern     (pat_q),
    .x           (x_d),
    .y           (line_cnt_d[7:0]),
    .bar_idx     (bar_idx_d),
    .solid_rgb   (solid_q),
    .frame_count (frame_count_q),
    .pix         (pix)
  );

  // Bus outputs for the upcoming byte. The pixel is evaluated on its high
  // byte and the low half held, so both bytes come from one pixel value.
  always_comb begin
    vsync_d  = vsync_q;
    href_d   = href_q;
    data_d   = data_q;
    pix_lo_d = pix_lo_q;
    if (byte_tick) begin
      vsync_d = (state_d == VSYNC);
      href_d  = (state_d == ACTIVE) && (byte_cnt_d < HREF_BYTES);
      data_d  = 8'h00;
      if (href_d) begin
        if (!phase_d) begin
          data_d   = pix[15:8];
          pix_lo_d = pix[7:0];
        end else begin
          data_d   = pix_lo_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      div_cnt_q     <= '0;
      pclk_q        <= 1'b0;
      byte_cnt_q    <= '0;
      line_cnt_q    <= '0;
      x_q           <= '0;
      phase_q       <= 1'b0;
      bar_px_q      <= '0;
      bar_idx_q     <= '0;
      pat_q         <= PAT_BARS;
      solid_q       <= '0;
      pix_lo_q      <= '0;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      data_q        <= '0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      pclk_q        <= pclk_d;
      byte_cnt_q    <= byte_cnt_d;
      line_cnt_q    <= line_cnt_d;
      x_q           <= x_d;
      phase_q       <= phase_d;
      bar_px_q      <= bar_px_d;
      bar_idx_q     <= bar_idx_d;
      pat_q         <= pat_d;
      solid_q       <= solid_d;
      pix_lo_q      <= pix_lo_d;
      vsync_q       <= vsync_d;
      href_q        <= href_d;
      data_q        <= data_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
      busy_q        <= busy_d;
    end
  end

  assign cam.pclk    = pclk_q;
  assign cam.vsync   = vsync_q;
  assign cam.href    = href_q;
  assign cam.data    = data_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;
  assign busy        = busy_q;

endmodule

// File: doc/dvp_pattern_tx.md
Name: dvp_pattern_tx

Overview:
- Camera-side transmitter for the 8-bit parallel DVP camera interface: drives pclk, vsync, href and 8-bit data with OV7670-style timing, emitting RGB565 two bytes per pixel, high byte first.
- Generated test patterns feed the existing camera capture path through the same camera_io pins (loopback on a spare header, or directly in simulation), so capture can be brought up without a sensor.

Parameters:
- H_ACTIVE, 640, active pixels per line; must be divisible by 8.
- V_ACTIVE, 480, active lines per frame.
- H_BLANK, 144, byte periods with href low at the end of each line.
- VSYNC_LINES, 3, lines with vsync high.
- V_BACK, 17, blank lines after vsync and before the first active line.
- V_FRONT, 10, blank lines after the last active line.
- PCLK_DIV, 2, clk cycles per pclk period; even, ≥2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  run frames while high
- pattern_sel  in  2  0 = colour bars, 1 = solid, 2 = coordinate, 3 = frame-seeded ramp
- solid_rgb  in  16  RGB565 value used by pattern 1
- cam_pclk  out  1  pixel byte clock
- cam_vsync  out  1  frame sync, active high
- cam_href  out  1  line valid, active high
- cam_data  out  8  byte bus
- frame_start  out  1  one-clk pulse when vsync rises
- frame_count  out  16  frames started, wraps at 16'hFFFF→0
- busy  out  1  high from vsync rise until the frame's last front-porch byte completes

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, divider 0, frame_count 0.
- pclk generation:
  - div_cnt counts 0..PCLK_DIV-1.
  - cam_pclk = (div_cnt >= PCLK_DIV/2), registered.
  - byte_tick asserts on the clk where div_cnt wraps to 0, i.e. the pclk falling edge.
  - cam_pclk runs continuously after reset, in IDLE too.
- Output timing: vsync, href and data change only on byte_tick, so the receiver samples them stable on the pclk rising edge.
- Line structure: LINE_BYTES = 2*H_ACTIVE + H_BLANK byte ticks.
  - Active lines: href high for the first 2*H_ACTIVE bytes, then low for H_BLANK bytes.
  - Outside href, data = 8'h00.
- FSM states and transitions, all taken on byte_tick:
  - IDLE → VSYNC when enable=1. pattern_sel and solid_rgb are latched here; frame_start pulses; frame_count increments.
  - VSYNC: vsync high for VSYNC_LINES*LINE_BYTES bytes → VBACK.
  - VBACK: V_BACK lines → ACTIVE.
  - ACTIVE: V_ACTIVE lines → VFRONT.
  - VFRONT: V_FRONT lines, then → VSYNC if enable=1, otherwise → IDLE.
- enable dropping mid-frame does not truncate the frame; the current frame always completes.
- Pattern changes take effect only at the next frame start.
- Counters:
  - x counts pixels 0..H_ACTIVE-1; byte_phase toggles each byte.
  - y counts active lines 0..V_ACTIVE-1.
  - Pixel value is taken at byte_phase 0; byte 0 = pix[15:8], byte 1 = pix[7:0].
- Patterns:
  - 0 colour bars: bar index advances every H_ACTIVE/8 pixels, with no divider. Colours: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - 1 solid: latched solid_rgb.
  - 2 coordinate: {y[7:0], x[7:0]}.
  - 3 ramp: x[15:0] + frame_count, mod 2^16.
- Reset mid-frame: all outputs drop to 0 on the next clk; the frame is abandoned.
- Simultaneous events: if reset and enable are asserted together, reset wins.

Decomposition:
- Package dvp_pkg holds:
  - state enum (IDLE, VSYNC, VBACK, ACTIVE, VFRONT);
  - pattern enum;
  - 8-entry RGB565 bar-colour constant array.
- Sub-module dvp_pixel_gen is combinational: inputs are pattern, x, y, bar index, solid value and frame_count; output is the 16-bit pixel. The top level holds the FSM, divider and counters.

Test Plan (params H_ACTIVE=8, V_ACTIVE=2, H_BLANK=2, VSYNC_LINES=1, V_BACK=1, V_FRONT=1, PCLK_DIV=2, so LINE_BYTES=18 and the frame is 90 bytes / 180 clk):
- Reset, then enable=1, pattern 2:
  - cam_pclk period is 2 clk;
  - vsync high for exactly 36 clk;
  - 2 href pulses of 32 clk each;
  - line 1 bytes: 01,00,01,01,…,01,07.
- Pattern 1, solid_rgb=F800: each active line carries 16 bytes alternating F8,00; data=00 during href low.
- Pattern 0: per line the byte pairs are FF FF, FF E0, 07 FF, 07 E0, F8 1F, F8 00, 00 1F, 00 00.
- enable held high over 3 frames:
  - frame_start pulses 3 times, 180 clk apart;
  - frame_count = 3;
  - pattern 3, frame 2: first active pixel = 0002.
- Drop enable at mid ACTIVE: the frame completes; busy falls after the last VFRONT byte; FSM is in IDLE; no further vsync.
- Assert reset mid-line: the next clk shows vsync, href, data, pclk, busy and frame_count all at 0; re-enable restarts with a full vsync.
